// File: rtl/hwce_weight_loader.sv
// rtl/hwce_weight_loader.sv - weight fetch engine: streams one filter set from TCDM into the weight buffer
module hwce_weight_loader #(
  parameter int NPF     = 2,
  parameter int N_COL   = 2,
  parameter int FS      = 3,
  parameter int N_WORDS = (NPF * N_COL * FS * FS + 1) / 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic                       engine_start_i,
  input  logic [31:0]                weights_base_i,
  output logic                       tcdm_req_o,
  output logic [31:0]                tcdm_add_o,
  input  logic                       tcdm_gnt_i,
  input  logic                       tcdm_r_valid_i,
  input  logic [31:0]                tcdm_r_data_i,
  output logic                       wl_we_o,
  output logic [$clog2(N_WORDS)-1:0] wl_addr_o,
  output logic [31:0]                wl_data_o,
  output logic [1:0]                 wl_be_o,
  output logic                       busy_o,
  output logic                       done_weightload_o
);

  localparam int AW = $clog2(N_WORDS);
  localparam int CW = $clog2(N_WORDS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_WORDS - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N_WORDS);
  // An odd tap count leaves the high half of the final word unused.
  localparam bit ODD_TAPS = ((NPF * N_COL * FS * FS) % 2) == 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] issue_cnt_q;
  logic [CW-1:0] recv_cnt_q;
  logic [31:0]   addr_q;

  logic load_req;
  logic issue_fire;
  logic rsp_fire;
  logic start_fire;

  assign start_fire = (state_q == ST_IDLE) && engine_start_i && !clear_i;
  assign load_req   = (state_q == ST_LOAD) && (issue_cnt_q < CNT_FULL) && !clear_i;
  assign issue_fire = load_req && tcdm_gnt_i;
  // Only responses to requests this load actually issued are accepted.
  assign rsp_fire   = (state_q != ST_IDLE) && tcdm_r_valid_i &&
                      (recv_cnt_q < issue_cnt_q) && !clear_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (engine_start_i) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (rsp_fire && (recv_cnt_q == CNT_LAST)) state_d = ST_DONE;
        else if (issue_fire && (issue_cnt_q == CNT_LAST)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (rsp_fire && (recv_cnt_q == CNT_LAST)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (clear_i) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      addr_q      <= '0;
    end else begin
      state_q <= state_d;
      if (clear_i) begin
        issue_cnt_q <= '0;
        recv_cnt_q  <= '0;
        addr_q      <= '0;
      end else if (start_fire) begin
        issue_cnt_q <= '0;
        recv_cnt_q  <= '0;
        addr_q      <= weights_base_i;
      end else begin
        if (issue_fire) begin
          issue_cnt_q <= issue_cnt_q + CW'(1);
          addr_q      <= addr_q + 32'd4;
        end
        if (rsp_fire) recv_cnt_q <= recv_cnt_q + CW'(1);
      end
    end
  end

  assign tcdm_req_o = load_req;
  assign tcdm_add_o = load_req ? addr_q : 32'd0;

  assign wl_we_o   = rsp_fire;
  assign wl_addr_o = rsp_fire ? recv_cnt_q[AW-1:0] : '0;
  assign wl_data_o = rsp_fire ? tcdm_r_data_i : 32'd0;

  always_comb begin
    wl_be_o = 2'b00;
    if (rsp_fire) begin
      if (ODD_TAPS && (recv_cnt_q == CNT_LAST)) wl_be_o = 2'b01;
      else wl_be_o = 2'b11;
    end
  end

  assign busy_o            = (state_q != ST_IDLE);
  assign done_weightload_o = (state_q == ST_DONE) && !clear_i;

endmodule

// File: tb/tb_hwce_weight_loader.sv
// tb/tb_hwce_weight_loader.sv - randomized bench for hwce_weight_loader against a count-based reference
module tb_hwce_weight_loader;
  localparam int N = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        clear_i = 1'b0;
  logic        engine_start_i = 1'b0;
  logic [31:0] weights_base_i = '0;
  logic        tcdm_req_o;
  logic [31:0] tcdm_add_o;
  logic        tcdm_gnt_i = 1'b0;
  logic        tcdm_r_valid_i = 1'b0;
  logic [31:0] tcdm_r_data_i = '0;
  logic        wl_we_o;
  logic [4:0]  wl_addr_o;
  logic [31:0] wl_data_o;
  logic [1:0]  wl_be_o;
  logic        busy_o;
  logic        done_weightload_o;

  hwce_weight_loader u_dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .engine_start_i(engine_start_i),
    .weights_base_i(weights_base_i), .tcdm_req_o(tcdm_req_o), .tcdm_add_o(tcdm_add_o),
    .tcdm_gnt_i(tcdm_gnt_i), .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_data_i(tcdm_r_data_i),
    .wl_we_o(wl_we_o), .wl_addr_o(wl_addr_o), .wl_data_o(wl_data_o), .wl_be_o(wl_be_o),
    .busy_o(busy_o), .done_weightload_o(done_weightload_o)
  );

  logic        o_start = 1'b0;
  logic [31:0] o_base = '0;
  logic        o_req;
  logic [31:0] o_add;
  logic        o_gnt = 1'b1;
  logic        o_rvalid = 1'b0;
  logic [31:0] o_rdata = '0;
  logic        o_we;
  logic [2:0]  o_waddr;
  logic [31:0] o_wdata;
  logic [1:0]  o_be;
  logic        o_busy;
  logic        o_done;

  hwce_weight_loader #(.NPF(1), .N_COL(1), .FS(3)) u_odd (
    .clk(clk), .rst_n(rst_n), .clear_i(1'b0), .engine_start_i(o_start),
    .weights_base_i(o_base), .tcdm_req_o(o_req), .tcdm_add_o(o_add),
    .tcdm_gnt_i(o_gnt), .tcdm_r_valid_i(o_rvalid), .tcdm_r_data_i(o_rdata),
    .wl_we_o(o_we), .wl_addr_o(o_waddr), .wl_data_o(o_wdata), .wl_be_o(o_be),
    .busy_o(o_busy), .done_weightload_o(o_done)
  );

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  // memory responder: in-order responses with per-request latency
  int          due_q[$];
  logic [31:0] dat_q[$];
  int          last_due = 0;
  int          gnt_mode = 0;
  int          lat_min = 1;
  int          lat_max = 1;

  // reference: one load = N words at base+4*i written to index i, then one done cycle
  bit          m_active = 1'b0;
  bit          m_done_phase = 1'b0;
  int          m_issue = 0;
  int          m_recv = 0;
  logic [31:0] m_base = '0;

  int r_req, r_wr, r_done, r_done_cyc, r_start_cyc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_done_phase = 1'b0;
    m_issue = 0;
    m_recv = 0;
  endtask

  task automatic clear_run_stats();
    r_req = 0; r_wr = 0; r_done = 0; r_done_cyc = 0; r_start_cyc = 0;
  endtask

  task automatic run_cycle(input bit start, input bit clr, input logic [31:0] base);
    bit exp_req, exp_we, exp_done, g;
    int lat, due;
    logic [31:0] ea;
    @(negedge clk);
    cyc++;
    engine_start_i = start;
    clear_i = clr;
    weights_base_i = base;
    case (gnt_mode)
      0: g = 1'b1;
      1: g = (cyc % 2) == 0;
      default: g = 1'($urandom_range(0, 1));
    endcase
    tcdm_gnt_i = g;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      tcdm_r_valid_i = 1'b1;
      tcdm_r_data_i = dat_q[0];
      void'(due_q.pop_front());
      void'(dat_q.pop_front());
    end else begin
      tcdm_r_valid_i = 1'b0;
      tcdm_r_data_i = $urandom;
    end
    #1;
    exp_req  = m_active && !clr && (m_issue < N);
    exp_we   = m_active && !clr && tcdm_r_valid_i && (m_recv < m_issue);
    exp_done = m_active && !clr && m_done_phase;

    n_tests++;
    if (tcdm_req_o !== exp_req) begin
      n_fail++; $display("FAIL req cyc=%0d got %b exp %b", cyc, tcdm_req_o, exp_req);
    end
    if (exp_req) begin
      ea = m_base + 32'(m_issue * 4);
      n_tests++;
      if (tcdm_add_o !== ea) begin
        n_fail++; $display("FAIL addr cyc=%0d got %h exp %h", cyc, tcdm_add_o, ea);
      end
    end
    n_tests++;
    if (wl_we_o !== exp_we) begin
      n_fail++; $display("FAIL we cyc=%0d got %b exp %b", cyc, wl_we_o, exp_we);
    end
    if (exp_we) begin
      ea = m_base + 32'(m_recv * 4);
      n_tests++;
      if (wl_addr_o !== 5'(m_recv) || wl_data_o !== mem_word(ea) || wl_be_o !== 2'b11) begin
        n_fail++;
        $display("FAIL wr cyc=%0d got idx %0d data %h be %b exp idx %0d data %h be 11",
                 cyc, wl_addr_o, wl_data_o, wl_be_o, m_recv, mem_word(ea));
      end
    end
    n_tests++;
    if (done_weightload_o !== exp_done) begin
      n_fail++; $display("FAIL done cyc=%0d got %b exp %b", cyc, done_weightload_o, exp_done);
    end
    n_tests++;
    if (busy_o !== m_active) begin
      n_fail++; $display("FAIL busy cyc=%0d got %b exp %b", cyc, busy_o, m_active);
    end

    if (tcdm_req_o && tcdm_gnt_i) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      due_q.push_back(due);
      dat_q.push_back(mem_word(tcdm_add_o));
      r_req++;
    end
    if (wl_we_o) r_wr++;
    if (done_weightload_o) begin r_done++; r_done_cyc = cyc; end

    if (clr) model_reset();
    else if (!m_active) begin
      if (start) begin
        m_active = 1'b1; m_base = base; m_issue = 0; m_recv = 0;
        m_done_phase = 1'b0; r_start_cyc = cyc;
      end
    end else if (m_done_phase) m_active = 1'b0;
    else begin
      if (exp_req && tcdm_gnt_i) m_issue++;
      if (exp_we) begin
        m_recv++;
        if (m_recv == N) m_done_phase = 1'b1;
      end
    end
  endtask

  task automatic run_until_idle(input int budget);
    int k;
    k = 0;
    while (m_active && k < budget) begin
      run_cycle(1'b0, 1'b0, 32'h0);
      k++;
    end
    n_tests++;
    if (m_active) begin
      n_fail++; $display("FAIL timeout after %0d cycles waiting for done", budget);
    end
    repeat (3) run_cycle(1'b0, 1'b0, 32'h0);
  endtask

  task automatic check_totals(input string name, input int exp_wr);
    n_tests++;
    if (r_req !== N || r_wr !== exp_wr || r_done !== 1) begin
      n_fail++;
      $display("FAIL %s totals got req %0d wr %0d done %0d exp req %0d wr %0d done 1",
               name, r_req, r_wr, r_done, N, exp_wr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (tcdm_req_o !== 1'b0 || tcdm_add_o !== 32'h0 || wl_we_o !== 1'b0 || wl_addr_o !== 5'h0 ||
        wl_data_o !== 32'h0 || wl_be_o !== 2'b00 || busy_o !== 1'b0 || done_weightload_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset outputs req %b add %h we %b addr %h data %h be %b busy %b done %b exp all 0",
               tcdm_req_o, tcdm_add_o, wl_we_o, wl_addr_o, wl_data_o, wl_be_o, busy_o, done_weightload_o);
    end
    rst_n = 1'b1;
    model_reset();
    repeat (2) run_cycle(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_basic();
    gnt_mode = 0; lat_min = 1; lat_max = 1;
    clear_run_stats();
    run_cycle(1'b1, 1'b0, 32'h0000_1000);
    run_until_idle(100);
    check_totals("basic", N);
    n_tests++;
    if (r_done_cyc - r_start_cyc !== 20) begin
      n_fail++; $display("FAIL basic_latency got %0d exp 20", r_done_cyc - r_start_cyc);
    end
  endtask

  task automatic test_stall_latency();
    gnt_mode = 1; lat_min = 1; lat_max = 4;
    clear_run_stats();
    run_cycle(1'b1, 1'b0, $urandom & 32'hFFFF_FFFC);
    run_until_idle(200);
    check_totals("stall", N);
  endtask

  task automatic test_restart_ignored();
    gnt_mode = 2; lat_min = 1; lat_max = 3;
    clear_run_stats();
    run_cycle(1'b1, 1'b0, 32'h0000_2000);
    for (int i = 0; i < 8; i++) run_cycle(i[0], 1'b0, 32'h0000_5000);
    run_until_idle(300);
    check_totals("restart", N);
  endtask

  task automatic test_clear();
    int k;
    gnt_mode = 0; lat_min = 3; lat_max = 3;
    clear_run_stats();
    run_cycle(1'b1, 1'b0, 32'h0000_3000);
    k = 0;
    while (m_issue < 7 && k < 50) begin
      run_cycle(1'b0, 1'b0, 32'h0);
      k++;
    end
    n_tests++;
    if (m_issue !== 7 || due_q.size() !== 3) begin
      n_fail++; $display("FAIL clear_setup got issue %0d pending %0d exp 7 and 3", m_issue, due_q.size());
    end
    run_cycle(1'b1, 1'b1, 32'h0000_7000);
    r_wr = 0; r_done = 0;
    repeat (6) run_cycle(1'b0, 1'b0, 32'h0);
    n_tests++;
    if (r_wr !== 0 || r_done !== 0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL clear_drop got wr %0d done %0d busy %b exp 0 0 0", r_wr, r_done, busy_o);
    end
    clear_run_stats();
    gnt_mode = 2; lat_min = 1; lat_max = 4;
    run_cycle(1'b1, 1'b0, 32'h0000_3000);
    run_until_idle(300);
    check_totals("clear_refetch", N);
  endtask

  task automatic test_reset_drain();
    int k;
    gnt_mode = 0; lat_min = 4; lat_max = 4;
    clear_run_stats();
    run_cycle(1'b1, 1'b0, 32'hFFFF_FFE0);
    k = 0;
    while (m_issue < N && k < 60) begin
      run_cycle(1'b0, 1'b0, 32'h0);
      k++;
    end
    n_tests++;
    if (!busy_o || m_recv >= N) begin
      n_fail++; $display("FAIL drain_setup got busy %b recv %0d exp busy 1 recv<%0d", busy_o, m_recv, N);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (tcdm_req_o !== 1'b0 || tcdm_add_o !== 32'h0 || wl_we_o !== 1'b0 || wl_addr_o !== 5'h0 ||
        wl_data_o !== 32'h0 || wl_be_o !== 2'b00 || busy_o !== 1'b0 || done_weightload_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drain outputs req %b we %b busy %b done %b exp all 0",
               tcdm_req_o, wl_we_o, busy_o, done_weightload_o);
    end
    model_reset();
    r_done = 0; r_wr = 0;
    repeat (3) run_cycle(1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    repeat (5) run_cycle(1'b0, 1'b0, 32'h0);
    n_tests++;
    if (r_done !== 0 || r_wr !== 0) begin
      n_fail++; $display("FAIL reset_drain_quiet got done %0d wr %0d exp 0 0", r_done, r_wr);
    end
    clear_run_stats();
    gnt_mode = 2; lat_min = 1; lat_max = 4;
    run_cycle(1'b1, 1'b0, 32'h0000_4000);
    run_until_idle(300);
    check_totals("after_reset", N);
  endtask

  task automatic test_odd_config();
    bit pend_v;
    logic [31:0] pend_d;
    int wcount, dones, nreq;
    logic [1:0] exp_be;
    pend_v = 1'b0; pend_d = '0; wcount = 0; dones = 0; nreq = 0;
    @(negedge clk);
    o_start = 1'b1; o_base = 32'h0000_8000;
    @(negedge clk);
    o_start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      o_rvalid = pend_v;
      o_rdata = pend_v ? pend_d : 32'h0;
      #1;
      if (o_req) begin
        n_tests++;
        if (o_add !== 32'h0000_8000 + 32'(nreq * 4)) begin
          n_fail++; $display("FAIL odd_addr got %h exp %h", o_add, 32'h0000_8000 + 32'(nreq * 4));
        end
        nreq++;
      end
      if (o_we) begin
        exp_be = (wcount == 4) ? 2'b01 : 2'b11;
        n_tests++;
        if (o_waddr !== 3'(wcount) || o_be !== exp_be ||
            o_wdata !== mem_word(32'h0000_8000 + 32'(wcount * 4))) begin
          n_fail++;
          $display("FAIL odd_wr got idx %0d be %b data %h exp idx %0d be %b", o_waddr, o_be, o_wdata, wcount, exp_be);
        end
        wcount++;
      end
      if (o_done) dones++;
      pend_v = o_req & o_gnt;
      pend_d = mem_word(o_add);
      @(negedge clk);
    end
    o_rvalid = 1'b0;
    n_tests++;
    if (wcount !== 5 || dones !== 1 || nreq !== 5) begin
      n_fail++; $display("FAIL odd_totals got wr %0d done %0d req %0d exp 5 1 5", wcount, dones, nreq);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_run_stats();
    test_reset();
    test_basic();
    test_stall_latency();
    test_restart_ignored();
    test_clear();
    test_reset_drain();
    test_odd_config();
    for (int i = 0; i < 3; i++) test_stall_latency();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hwce_weight_loader.md
HWCE_WEIGHT_LOADER -- requirements
Module: hwce_weight_loader

Interface
REQ-001 Parameter NPF, default 2, number of parallel filters per SoP.
REQ-002 Parameter N_COL, default 2, number of SoP columns.
REQ-003 Parameter FS, default 3, filter side; taps per filter = FS*FS.
REQ-004 Parameter N_WORDS, derived as ceil(NPF*N_COL*FS*FS/2), default 18, 32-bit words fetched per load; two 16-bit weights per word, low half first.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 clear_i  in  1  synchronous abort to IDLE.
REQ-008 engine_start_i  in  1  one-cycle start pulse from the wrapper FSM.
REQ-009 weights_base_i  in  32  byte address of the first weight word; sampled only on an accepted start.
REQ-010 tcdm_req_o  out  1  memory read request.
REQ-011 tcdm_add_o  out  32  memory read address.
REQ-012 tcdm_gnt_i  in  1  request accepted in the cycle where it is high together with tcdm_req_o.
REQ-013 tcdm_r_valid_i  in  1  read data valid.
REQ-014 tcdm_r_data_i  in  32  read data.
REQ-015 wl_we_o  out  1  weight buffer write enable.
REQ-016 wl_addr_o  out  $clog2(N_WORDS)  weight buffer word index.
REQ-017 wl_data_o  out  32  weight buffer write data.
REQ-018 wl_be_o  out  2  half-word enables; bit 0 = low weight, bit 1 = high weight.
REQ-019 busy_o  out  1  high in every state except IDLE.
REQ-020 done_weightload_o  out  1  one-cycle completion pulse to the wrapper FSM.

Function
REQ-021 FSM states SHALL be IDLE, LOAD, DRAIN and DONE.
REQ-022 IDLE -> LOAD SHALL occur on engine_start_i=1; at that edge weights_base_i is latched into the address register and issue/receive counters are cleared to 0.
REQ-023 engine_start_i SHALL be ignored in any state other than IDLE.
REQ-024 In LOAD, tcdm_req_o SHALL be 1 while issue count < N_WORDS; tcdm_add_o SHALL equal base + 4*issue count; address and request SHALL stay stable until granted.
REQ-025 Each req&gnt cycle SHALL increment issue count by 1 and the address by 4; a new request may follow on the next cycle, with no outstanding-request limit.
REQ-026 LOAD -> DRAIN SHALL occur on the edge granting word N_WORDS-1; tcdm_req_o SHALL be 0 in DRAIN, DONE and IDLE.
REQ-027 Read responses SHALL arrive in request order; each tcdm_r_valid_i=1, while receive count < issue count, SHALL produce wl_we_o=1 in the same cycle, with wl_data_o=tcdm_r_data_i and wl_addr_o=receive count, and SHALL increment receive count.
REQ-028 wl_be_o SHALL be 2'b11 for every word except the last when NPF*N_COL*FS*FS is odd, where it SHALL be 2'b01.
REQ-029 tcdm_r_valid_i with receive count = issue count, or in IDLE, SHALL be ignored (no write, no count change).
REQ-030 A grant and a response in the same cycle SHALL both be counted.
REQ-031 DRAIN -> DONE SHALL occur on the edge where receive count reaches N_WORDS, including when that response arrives in LOAD on the final grant cycle.
REQ-032 DONE SHALL assert done_weightload_o=1 for exactly one cycle, then go to IDLE.
REQ-033 The address adder SHALL wrap modulo 2^32 without flagging.
REQ-034 clear_i=1 SHALL force IDLE on the next edge, zero both counters, deassert all outputs and suppress done; clear_i SHALL take priority over engine_start_i.
REQ-035 Responses arriving after a clear SHALL be dropped per REQ-029.

Reset
REQ-036 On rst_n=0, state SHALL be IDLE and counters and address SHALL be 0; tcdm_req_o, tcdm_add_o, wl_we_o, wl_addr_o, wl_data_o, wl_be_o, busy_o and done_weightload_o SHALL all be 0.
REQ-037 Reset asserted mid-load SHALL abort immediately, without a done pulse; the first start after reset release SHALL behave as from power-up.

Verification
REQ-038 Start with base=0x1000, gnt always 1, r_valid 1 cycle after gnt -> addresses 0x1000..0x1044, 18 writes idx 0..17, be=2'b11, one done pulse 20 cycles after start.
REQ-039 Start with gnt low every other cycle, random r_valid latency 1-4 -> same 18 writes in order, addresses never skip, exactly one done pulse.
REQ-040 Second engine_start_i pulse during LOAD -> ignored; total 18 requests; busy_o stays 1 until after the done pulse.
REQ-041 clear_i at issue count 7 with 3 responses pending -> IDLE next cycle, late r_valid cause no write, no done pulse; next start refetches from word 0.
REQ-042 NPF=1, N_COL=1, FS=3 (9 weights) -> 5 words, last write be=2'b01.
REQ-043 rst_n pulsed low during DRAIN -> all outputs 0 immediately, no done pulse; a subsequent start completes normally.
